// File: rtl/cpu_hs_pkg.sv
// Shared types for the buffered four-phase stage-to-stage link.
// Contents:
//     hs_in_state_e   - upstream (producer-side) handshake states
//     hs_out_state_e  - downstream (consumer-side) handshake states
//     HS_DEFAULT_SYNC - default synchroniser depth for req/ack inputs
package cpu_hs_pkg;

    typedef enum logic {
        IN_IDLE,
        IN_ACK
    } hs_in_state_e;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_REQ,
        OUT_WAIT
    } hs_out_state_e;

    localparam int HS_DEFAULT_SYNC = 2;

endpackage

// File: rtl/hs_sync.sv
// One-bit flop chain used to bring a handshake line into the local clock.
// Ports:
//     clk   - clock, all flops on posedge
//     reset - synchronous active-high reset, clears the chain
//     d_i   - raw input line
//     q_o   - input delayed by STAGES cycles (combinational copy when STAGES=0)
module hs_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign q_o = d_i;
        end else begin : g_chain
            logic [STAGES-1:0] chain_q;

            // Shift the raw line through STAGES flops; the last flop is the
            // only one the rest of the link is allowed to look at.
            always_ff @(posedge clk) begin
                if (reset) begin
                    chain_q <= '0;
                end else begin
                    chain_q[0] <= d_i;
                    for (int i = 1; i < STAGES; i++) begin
                        chain_q[i] <= chain_q[i-1];
                    end
                end
            end

            assign q_o = chain_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/hs_link_fifo.sv
// Buffered four-phase req/ack link placed between two CPU pipeline stages.
// An input handshake FSM writes payloads into a DEPTH-entry FIFO, and an
// output handshake FSM moves the oldest entry into a holding register and
// offers it downstream. A flush pulse empties the FIFO but never retracts the
// entry already being offered.
// Ports:
//     clk, reset        - single clock, synchronous active-high reset
//     in_req / in_ack   - upstream four-phase handshake, payload on in_data
//     out_req / out_ack - downstream four-phase handshake, payload on out_data
//     flush             - one-cycle pulse discarding buffered entries
//     level             - FIFO occupancy (holding register not included)
//     full              - level == DEPTH
module hs_link_fifo
    import cpu_hs_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = HS_DEFAULT_SYNC
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_req,
    output logic                     in_ack,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_req,
    input  logic                     out_ack,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic                 in_req_s;
    logic                 out_ack_s;
    hs_in_state_e         in_state_q, in_state_d;
    hs_out_state_e        out_state_q, out_state_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;
    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 full_w;

    hs_sync #(.STAGES(SYNC_STAGES)) u_sync_req (
        .clk   (clk),
        .reset (reset),
        .d_i   (in_req),
        .q_o   (in_req_s)
    );

    hs_sync #(.STAGES(SYNC_STAGES)) u_sync_ack (
        .clk   (clk),
        .reset (reset),
        .d_i   (out_ack),
        .q_o   (out_ack_s)
    );

    assign full_w = (level_q == LVL_W'(DEPTH));

    // Upstream side: take a payload only when there is room, then hold ack
    // high until the producer drops its request. A flush in the accept cycle
    // still completes the handshake; only the write into storage is dropped.
    always_comb begin
        in_state_d = in_state_q;
        accept     = 1'b0;
        case (in_state_q)
            IN_IDLE: begin
                if (in_req_s && !full_w) begin
                    accept     = 1'b1;
                    in_state_d = IN_ACK;
                end
            end
            IN_ACK: begin
                if (!in_req_s) begin
                    in_state_d = IN_IDLE;
                end
            end
            default: in_state_d = IN_IDLE;
        endcase
    end

    assign push = accept && !flush;

    // Downstream side: load the holding register from the FIFO head, offer
    // it, and wait for the full ack rise/fall before offering the next one.
    // Flush blocks the load so a discarded entry can never leak out.
    always_comb begin
        out_state_d = out_state_q;
        pop         = 1'b0;
        case (out_state_q)
            OUT_IDLE: begin
                if ((level_q != '0) && !flush) begin
                    pop         = 1'b1;
                    out_state_d = OUT_REQ;
                end
            end
            OUT_REQ: begin
                if (out_ack_s) begin
                    out_state_d = OUT_WAIT;
                end
            end
            OUT_WAIT: begin
                if (!out_ack_s) begin
                    out_state_d = OUT_IDLE;
                end
            end
            default: out_state_d = OUT_IDLE;
        endcase
    end

    // Pointer and occupancy bookkeeping. Pointers wrap naturally because
    // DEPTH is a power of two; flush snaps the read pointer onto the write
    // pointer so everything buffered is forgotten in one cycle.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        out_data_d = out_data_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                level_d = level_q + LVL_W'(1);
            end else if (!push && pop) begin
                level_d = level_q - LVL_W'(1);
            end
        end
        if (pop) begin
            out_data_d = mem_q[rd_ptr_q];
        end
    end

    // Control state and the holding register; everything here is cleared by
    // reset, which also aborts any handshake in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_state_q  <= IN_IDLE;
            out_state_q <= OUT_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_data_q  <= '0;
        end else begin
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_data_q  <= out_data_d;
        end
    end

    // Payload storage has no reset; stale contents are unreachable because
    // the pointers and level are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign in_ack   = (in_state_q == IN_ACK);
    assign out_req  = (out_state_q == OUT_REQ);
    assign out_data = out_data_q;
    assign level    = level_q;
    assign full     = full_w;

endmodule
